mod_if: RTL and testbench

Fetch stage of the 5-stage pipeline, directly upstream of `mod_ID`. It owns the PC register and runs the request/ready handshake to instruction memory. It holds the IF/ID pipeline register that feeds `instruction` and `pc` to decode. It also owns a one-entry hold buffer, so a fetch that completes during a stall is not lost, and it handles branch redirect/flush and HLT detection.

---
 rtl/mod_if.sv | 114 +++++++++++
 tb/tb_mod_if.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_if.sv
// Instruction fetch stage: PC register, imem request/ready handshake, one-entry hold buffer,
// IF/ID pipeline register, branch redirect/flush with in-flight drain, and HLT detection.
module mod_if #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalt} state_e;

  state_e      state_q;
  logic [15:0] pc_reg;
  logic [15:0] drain_addr_q;
  logic        hold_valid_q;
  logic [15:0] hold_instr_q;
  logic [15:0] hold_pc_q;
  logic        ifid_valid_q;
  logic [15:0] ifid_instr_q;
  logic [15:0] ifid_pc_q;

  logic [15:0] pc_plus2;
  logic        fetch_done;
  logic        is_hlt;

  // No request while the hold buffer is occupied, so a stalled fetch can never be lost.
  assign imem_req   = ((state_q == StFetch) && !hold_valid_q) || (state_q == StDrain);
  assign imem_addr  = (state_q == StDrain) ? drain_addr_q : pc_reg;
  assign pc_plus2   = pc_reg + 16'd2;
  assign fetch_done = (state_q == StFetch) && !hold_valid_q && imem_ready;
  assign is_hlt     = (imem_data[15:12] == 4'hF);

  assign valid       = ifid_valid_q;
  assign instruction = ifid_valid_q ? ifid_instr_q : 16'h0000;
  assign pc          = ifid_valid_q ? ifid_pc_q : 16'h0000;
  assign halted      = (state_q == StHalt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_reg       <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 16'h0000;
      hold_pc_q    <= 16'h0000;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 16'h0000;
      ifid_pc_q    <= 16'h0000;
    end else if (flush) begin
      ifid_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      pc_reg       <= redirect_pc;
      if (imem_req && !imem_ready) begin
        // Memory still owes a response; keep presenting the original address until it lands.
        state_q <= StDrain;
        if (state_q != StDrain) begin
          drain_addr_q <= pc_reg;
        end
      end else begin
        state_q <= StFetch;
      end
    end else begin
      if (!stall) begin
        if (hold_valid_q) begin
          ifid_valid_q <= 1'b1;
          ifid_instr_q <= hold_instr_q;
          ifid_pc_q    <= hold_pc_q;
          hold_valid_q <= 1'b0;
        end else if (fetch_done) begin
          ifid_valid_q <= 1'b1;
          ifid_instr_q <= imem_data;
          ifid_pc_q    <= pc_plus2;
        end else begin
          ifid_valid_q <= 1'b0;
        end
      end else if (fetch_done) begin
        hold_valid_q <= 1'b1;
        hold_instr_q <= imem_data;
        hold_pc_q    <= pc_plus2;
      end

      unique case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: begin
          if (fetch_done) begin
            if (is_hlt) begin
              state_q <= StHalt;
            end else begin
              pc_reg <= pc_plus2;
            end
          end
        end
        StDrain: begin
          if (imem_ready) begin
            state_q <= StFetch;
          end
        end
        StHalt:  state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_if.sv
// Bench for mod_if: directed walk through the fetch scenarios, then randomized stall/flush/
// latency traffic checked against an in-order instruction-stream reference model.
module tb_mod_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        valid;
  logic        halted;

  int checks;
  int errors;

  mod_if #(
    .RESET_PC(16'h0010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .instruction(instruction),
    .pc         (pc),
    .valid      (valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of address; opcode field never reaches 4'hF.
  function automatic logic [15:0] memw(input logic [15:0] a);
    return ((a * 16'h0131) ^ 16'h5a5a) & 16'h7fff;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] p);
    check({tag, "_ifid"}, {15'd0, valid, instruction, pc}, {15'd0, v, ins, p});
  endtask

  task automatic check_bus(input string tag, input logic req, input logic [15:0] addr);
    check({tag, "_bus"}, {15'd0, imem_req, imem_addr}, {15'd0, req, addr});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ifid"}, {15'd0, valid, instruction, pc}, 32'h0);
    check({tag, "_bus"}, {14'd0, halted, imem_req, imem_addr}, {14'd0, 1'b0, 1'b0, 16'h0010});
  endtask

  logic        busy;
  int          wait_left;
  logic        prev_pend;
  logic [15:0] prev_addr;
  logic [15:0] exp_next;
  int          deliveries;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready = 1'b0;
    imem_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    rst = 1'b1;
    check("idle_no_req", {31'd0, imem_req}, 32'd0);
    cyc();
    check_bus("first_req", 1'b1, 16'h0010);

    // Zero-wait memory, one instruction per cycle
    imem_ready = 1'b1;
    imem_data = 16'h1123;
    cyc();
    check_ifid("zw0", 1'b1, 16'h1123, 16'h0012);
    check_bus("zw0", 1'b1, 16'h0012);
    imem_data = 16'h2456;
    cyc();
    check_ifid("zw1", 1'b1, 16'h2456, 16'h0014);
    check_bus("zw1", 1'b1, 16'h0014);

    // Stall while the fetch at 0014 completes: hold buffer captures it
    stall = 1'b1;
    imem_data = 16'h3789;
    cyc();
    check_ifid("stall0", 1'b1, 16'h2456, 16'h0014);
    check("stall0_noreq", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b0;
    cyc();
    check_ifid("stall1", 1'b1, 16'h2456, 16'h0014);
    check("stall1_noreq", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    cyc();
    check_ifid("unstall", 1'b1, 16'h3789, 16'h0016);
    check_bus("unstall", 1'b1, 16'h0016);

    // Three-cycle memory latency
    cyc();
    check_ifid("lat0", 1'b0, 16'h0000, 16'h0000);
    check_bus("lat0", 1'b1, 16'h0016);
    cyc();
    check_ifid("lat1", 1'b0, 16'h0000, 16'h0000);
    check_bus("lat1", 1'b1, 16'h0016);
    imem_ready = 1'b1;
    imem_data = 16'h4abc;
    cyc();
    check_ifid("lat2", 1'b1, 16'h4abc, 16'h0018);
    check_bus("lat2", 1'b1, 16'h0018);

    for (int k = 0; k < 4; k++) begin
      imem_data = memw(imem_addr);
      cyc();
    end
    check_ifid("seq", 1'b1, memw(16'h001e), 16'h0020);
    check_bus("seq", 1'b1, 16'h0020);

    // Flush while a request to 0020 is in flight: drain then redirect
    imem_ready = 1'b0;
    flush = 1'b1;
    redirect_pc = 16'h0100;
    cyc();
    flush = 1'b0;
    check_ifid("drain0", 1'b0, 16'h0000, 16'h0000);
    check_bus("drain0", 1'b1, 16'h0020);
    cyc();
    check_ifid("drain1", 1'b0, 16'h0000, 16'h0000);
    check_bus("drain1", 1'b1, 16'h0020);
    imem_ready = 1'b1;
    imem_data = 16'h1111;
    cyc();
    check_ifid("drain2", 1'b0, 16'h0000, 16'h0000);
    check_bus("drain2", 1'b1, 16'h0100);

    // Flush coinciding with ready: data dropped, no PC increment
    flush = 1'b1;
    redirect_pc = 16'h0030;
    imem_data = 16'h2222;
    cyc();
    flush = 1'b0;
    check_ifid("flush_rdy", 1'b0, 16'h0000, 16'h0000);
    check_bus("flush_rdy", 1'b1, 16'h0030);

    // HLT
    imem_data = 16'hF000;
    cyc();
    check_ifid("hlt", 1'b1, 16'hF000, 16'h0032);
    check("hlt_state", {30'd0, halted, imem_req}, {30'd0, 1'b1, 1'b0});
    imem_data = 16'h3333;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("halted_idle", {29'd0, halted, imem_req, valid}, {29'd0, 1'b1, 1'b0, 1'b0});
    end
    flush = 1'b1;
    redirect_pc = 16'h0040;
    cyc();
    flush = 1'b0;
    check("unhalt", {31'd0, halted}, 32'd0);
    check_bus("unhalt", 1'b1, 16'h0040);
    imem_data = 16'h1234;
    cyc();
    check_ifid("resume", 1'b1, 16'h1234, 16'h0042);
    check_bus("resume", 1'b1, 16'h0042);

    // PC wraps modulo 2^16
    flush = 1'b1;
    redirect_pc = 16'hFFFE;
    cyc();
    flush = 1'b0;
    check_bus("wrap0", 1'b1, 16'hFFFE);
    imem_data = 16'h0abc;
    cyc();
    check_ifid("wrap1", 1'b1, 16'h0abc, 16'h0000);
    check_bus("wrap1", 1'b1, 16'h0000);

    // Flush beats stall and empties a full hold buffer
    stall = 1'b1;
    imem_data = 16'h0def;
    cyc();
    check_ifid("hold_full", 1'b1, 16'h0abc, 16'h0000);
    check("hold_full_noreq", {31'd0, imem_req}, 32'd0);
    flush = 1'b1;
    redirect_pc = 16'h0200;
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    check_ifid("flush_stall", 1'b0, 16'h0000, 16'h0000);
    check_bus("flush_stall", 1'b1, 16'h0200);

    // Asynchronous reset mid-wait
    imem_ready = 1'b0;
    cyc();
    check_bus("pre_rst", 1'b1, 16'h0200);
    #1 rst = 1'b0;
    #1 check_reset("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    check("rst_idle", {31'd0, imem_req}, 32'd0);
    cyc();
    check_bus("rst_first", 1'b1, 16'h0010);

    // Randomized traffic against the in-order stream model
    busy = 1'b0;
    wait_left = 0;
    prev_pend = 1'b0;
    prev_addr = 16'h0000;
    exp_next = 16'h0000;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_pend) check("proto_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, prev_addr});
      if (!valid) check("bubble_zero", {instruction, pc}, 32'h0);
      stall = ($urandom_range(0, 3) == 0);
      flush = (i == 0) || ($urandom_range(0, 29) == 0);
      redirect_pc = 16'($urandom) & 16'hfffe;
      imem_ready = 1'b0;
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = $urandom_range(0, 3);
        end
        if (wait_left == 0) begin
          imem_ready = 1'b1;
          busy = 1'b0;
        end else begin
          wait_left--;
        end
      end
      imem_data = memw(imem_addr);
      if (valid && !stall && !flush) begin
        check("deliver_pc", {16'd0, pc}, {16'd0, 16'(exp_next + 16'd2)});
        check("deliver_instr", {16'd0, instruction}, {16'd0, memw(exp_next)});
        exp_next = 16'(exp_next + 16'd2);
        deliveries++;
      end
      if (flush) exp_next = redirect_pc;
      prev_pend = imem_req && !imem_ready;
      prev_addr = imem_addr;
      cyc();
    end
    flush = 1'b0;
    stall = 1'b0;
    check("deliveries", {31'd0, deliveries > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
